// File: rtl/move_scheduler.sv
// move_scheduler: buffered point-to-point moves, trapezoidal profile advanced on a 1 s tick; MOVE_SCHED_ABORT_EN adds abort_i.
// Latency: command reaches ACCEL 3 cycles after push; pos_o/vel_o update the cycle after a tick; done pulses the cycle after the last tick.
// Backpressure: cmd_ready_o drops while the c_depth-entry command FIFO is full.

module fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push_vld && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
endmodule

module move_scheduler #(
    parameter int unsigned c_clkfreq  = 100000000,
    parameter int unsigned c_depth    = 4,
    parameter logic [7:0]  c_accel    = 8'd2,
    parameter logic [9:0]  c_home_pos = 10'd0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MOVE_SCHED_ABORT_EN
    input  logic        abort_i,
`endif
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [9:0]  cmd_dest_i,
    input  logic [7:0]  cmd_vmax_i,
    output logic [9:0]  pos_o,
    output logic [7:0]  vel_o,
    output logic        busy_o,
    output logic        move_done_o,
    output logic [15:0] move_seconds_o,
    output logic [7:0]  moves_done_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ACCEL, S_CRUISE, S_DECEL, S_DONE
    } state_t;

    localparam int unsigned CW = (c_clkfreq > 1) ? $clog2(c_clkfreq) : 1;

    logic [CW-1:0] r_tick_cnt;
    logic          w_tick;
    logic          w_abort;

    state_t        r_state, w_state_nxt;
    logic [9:0]    r_pos, w_pos_nxt;
    logic [7:0]    r_vel, w_vel_nxt;
    logic [15:0]   r_sec, w_sec_nxt;
    logic          r_dir, w_dir_nxt;
    logic [9:0]    r_dest, w_dest_nxt;
    logic [7:0]    r_vmax, w_vmax_nxt;
    logic [15:0]   r_move_seconds;
    logic [7:0]    r_moves_done;

    logic          w_pop;
    logic [17:0]   w_fifo_dat;
    logic          w_full;
    logic          w_empty;

    logic [9:0]    w_rem;
    logic          w_near;
    logic [8:0]    w_vsum;
    logic [7:0]    w_vacc;
    logic [7:0]    w_vdec;
    logic          w_decel;
    logic [7:0]    w_vnext;
    logic [9:0]    w_step;

`ifdef MOVE_SCHED_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign w_tick = (r_tick_cnt == CW'(c_clkfreq - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tick_cnt <= '0;
        else        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end

    fifo #(.W(18), .DEPTH(c_depth)) u_cmd_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_abort),
        .i_push_vld (cmd_valid_i && !w_abort),
        .i_push_dat ({cmd_dest_i, cmd_vmax_i}),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Profile arithmetic: remaining distance, braking test and candidate velocities.
    assign w_rem   = r_dir ? (r_dest - r_pos) : (r_pos - r_dest);
    assign w_near  = ({1'b0, w_rem} <= {2'b00, r_vel, 1'b0});
    assign w_vsum  = {1'b0, r_vel} + {1'b0, c_accel};
    assign w_vacc  = (w_vsum >= {1'b0, r_vmax}) ? r_vmax : w_vsum[7:0];
    assign w_vdec  = (r_vel > c_accel) ? (r_vel - c_accel) : 8'd1;
    assign w_decel = (r_state == S_DECEL) || w_near;
    assign w_vnext = w_decel ? w_vdec : ((r_state == S_ACCEL) ? w_vacc : r_vel);
    assign w_step  = ({2'b00, w_vnext} >= w_rem) ? w_rem : {2'b00, w_vnext};

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_vel_nxt   = r_vel;
        w_sec_nxt   = r_sec;
        w_dir_nxt   = r_dir;
        w_dest_nxt  = r_dest;
        w_vmax_nxt  = r_vmax;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty && !w_abort) begin
                    w_pop       = 1'b1;
                    w_dest_nxt  = w_fifo_dat[17:8];
                    w_vmax_nxt  = (w_fifo_dat[7:0] == 8'd0) ? 8'd1 : w_fifo_dat[7:0];
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_dir_nxt   = (r_dest >= r_pos);
                w_sec_nxt   = 16'd0;
                w_vel_nxt   = 8'd0;
                w_state_nxt = (r_dest == r_pos) ? S_DONE : S_ACCEL;
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (w_tick) begin
                    w_sec_nxt = (r_sec == 16'hFFFF) ? r_sec : r_sec + 16'd1;
                    if (w_decel)
                        w_state_nxt = S_DECEL;
                    else if (r_state == S_ACCEL && w_vacc == r_vmax)
                        w_state_nxt = S_CRUISE;
                    w_pos_nxt = r_dir ? (r_pos + w_step) : (r_pos - w_step);
                    w_vel_nxt = w_step[7:0];
                    if (w_step == w_rem) begin
                        w_state_nxt = S_DONE;
                        w_vel_nxt   = 8'd0;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // An aborted move freezes where it stands and reports through DONE.
        if (w_abort && (r_state inside {S_LOAD, S_ACCEL, S_CRUISE, S_DECEL})) begin
            w_state_nxt = S_DONE;
            w_pos_nxt   = r_pos;
            w_vel_nxt   = 8'd0;
            w_sec_nxt   = (r_state == S_LOAD) ? 16'd0 : r_sec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pos          <= c_home_pos;
            r_vel          <= 8'd0;
            r_sec          <= 16'd0;
            r_dir          <= 1'b1;
            r_dest         <= c_home_pos;
            r_vmax         <= 8'd1;
            r_move_seconds <= 16'd0;
            r_moves_done   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_vel   <= w_vel_nxt;
            r_sec   <= w_sec_nxt;
            r_dir   <= w_dir_nxt;
            r_dest  <= w_dest_nxt;
            r_vmax  <= w_vmax_nxt;
            if (w_state_nxt == S_DONE && r_state != S_DONE) begin
                r_move_seconds <= w_sec_nxt;
                if (!w_abort) r_moves_done <= r_moves_done + 8'd1;
            end
        end
    end

    assign cmd_ready_o    = !w_full;
    assign busy_o         = (r_state != S_IDLE) || !w_empty;
    assign move_done_o    = (r_state == S_DONE);
    assign pos_o          = r_pos;
    assign vel_o          = r_vel;
    assign move_seconds_o = r_move_seconds;
    assign moves_done_o   = r_moves_done;
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a 4-cycle tick, accel 2, home 0.
module tb_move_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic [9:0]  cmd_dest_i;
    logic [7:0]  cmd_vmax_i;
    logic        cmd_ready_o;
    logic [9:0]  pos_o;
    logic [7:0]  vel_o;
    logic        busy_o;
    logic        move_done_o;
    logic [15:0] move_seconds_o;
    logic [7:0]  moves_done_o;
`ifdef MOVE_SCHED_ABORT_EN
    logic        abort_i;
`endif

    int total = 0;
    int bad   = 0;
    int m_cnt;

    int fwd_pos[7] = '{2, 6, 12, 16, 18, 19, 20};
    int fwd_vel[6] = '{2, 4, 6, 4, 2, 1};
    int rev_pos[8] = '{18, 15, 12, 9, 8, 7, 6, 5};
    int rev_vel[7] = '{2, 3, 3, 3, 1, 1, 1};
    int bb_dest[5] = '{8, 3, 3, 12, 10};
    int bb_vmax[5] = '{4, 2, 9, 0, 255};
    int bb_secs[5] = '{3, 4, 0, 9, 1};

    move_scheduler #(
        .c_clkfreq  (4),
        .c_depth    (4),
        .c_accel    (8'd2),
        .c_home_pos (10'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef MOVE_SCHED_ABORT_EN
        .abort_i        (abort_i),
`endif
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_dest_i     (cmd_dest_i),
        .cmd_vmax_i     (cmd_vmax_i),
        .pos_o          (pos_o),
        .vel_o          (vel_o),
        .busy_o         (busy_o),
        .move_done_o    (move_done_o),
        .move_seconds_o (move_seconds_o),
        .moves_done_o   (moves_done_o)
    );

    always #5 clk = ~clk;

    // Reference tick phase: the tick is high in cycles where m_cnt == 3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= (m_cnt == 3) ? 0 : m_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [9:0] d, input logic [7:0] v, input bit align);
        int n = 0;
        if (align) begin
            while (m_cnt != 0 && n < 8) begin
                @(negedge clk);
                n++;
            end
        end
        cmd_valid_i = 1'b1;
        cmd_dest_i  = d;
        cmd_vmax_i  = v;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic next_tick();
        int n = 0;
        while (m_cnt != 3 && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (!move_done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = move_done_o;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int pulses;
        rst_n       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_dest_i  = 10'd0;
        cmd_vmax_i  = 8'd0;
`ifdef MOVE_SCHED_ABORT_EN
        abort_i     = 1'b0;
`endif
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        check("rst_pos", 32'(pos_o), 0);
        check("rst_vel", 32'(vel_o), 0);
        check("rst_done", 32'(move_done_o), 0);
        check("rst_secs", 32'(move_seconds_o), 0);
        check("rst_moves", 32'(moves_done_o), 0);
        check("rst_ready", 32'(cmd_ready_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        rst_n = 1'b1;

        // Forward move 0 -> 20 at vmax 6
        push(10'd20, 8'd6, 1'b1);
        for (int i = 0; i < 7; i++) begin
            next_tick();
            check("fwd_pos", 32'(pos_o), fwd_pos[i]);
            if (i < 6) check("fwd_vel", 32'(vel_o), fwd_vel[i]);
        end
        check("fwd_done", 32'(move_done_o), 1);
        check("fwd_secs", 32'(move_seconds_o), 7);
        check("fwd_moves", 32'(moves_done_o), 1);
        check("fwd_vel_done", 32'(vel_o), 0);
        cyc();
        check("fwd_done_off", 32'(move_done_o), 0);
        check("fwd_idle", 32'(busy_o), 0);

        // Reverse move 20 -> 5 clamped at vmax 3
        push(10'd5, 8'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            check("rev_pos", 32'(pos_o), rev_pos[i]);
            if (i < 7) check("rev_vel", 32'(vel_o), rev_vel[i]);
        end
        check("rev_done", 32'(move_done_o), 1);
        check("rev_secs", 32'(move_seconds_o), 8);
        check("rev_moves", 32'(moves_done_o), 2);
        cyc();

        // Zero-length move: done 3 cycles after the push cycle
        push(10'd5, 8'd0, 1'b0);
        check("zero_early1", 32'(move_done_o), 0);
        cyc();
        check("zero_early2", 32'(move_done_o), 0);
        cyc();
        check("zero_done", 32'(move_done_o), 1);
        check("zero_secs", 32'(move_seconds_o), 0);
        check("zero_moves", 32'(moves_done_o), 3);
        check("zero_pos", 32'(pos_o), 5);
        cyc();

        // Reset while cruising toward 100
        push(10'd100, 8'd4, 1'b1);
        next_tick();
        next_tick();
        next_tick();
        check("cru_pos", 32'(pos_o), 15);
        check("cru_vel", 32'(vel_o), 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pos", 32'(pos_o), 0);
        check("mid_rst_vel", 32'(vel_o), 0);
        check("mid_rst_moves", 32'(moves_done_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_ready", 32'(cmd_ready_o), 1);
        cyc();
        cyc();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (move_done_o) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 0);
        check("mid_rst_idle", 32'(busy_o), 0);
        check("mid_rst_pos_hold", 32'(pos_o), 0);

        // Five back-to-back commands; the sixth sees a full FIFO
        for (int i = 0; i < 5; i++) begin
            cmd_valid_i = 1'b1;
            cmd_dest_i  = 10'(bb_dest[i]);
            cmd_vmax_i  = 8'(bb_vmax[i]);
            cyc();
        end
        check("bb_ready_full", 32'(cmd_ready_o), 0);
        cmd_dest_i = 10'd500;
        cmd_vmax_i = 8'd9;
        cyc();
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_done(ok);
            check("bb_done_seen", 32'(ok), 1);
            check("bb_pos", 32'(pos_o), bb_dest[i]);
            check("bb_secs", 32'(move_seconds_o), bb_secs[i]);
            check("bb_moves", 32'(moves_done_o), i + 1);
            cyc();
        end
        for (int i = 0; i < 20; i++) cyc();
        check("bb_final_moves", 32'(moves_done_o), 5);
        check("bb_final_pos", 32'(pos_o), 10);
        check("bb_final_busy", 32'(busy_o), 0);

`ifdef MOVE_SCHED_ABORT_EN
        // Abort during ACCEL with two commands queued behind it
        push(10'd200, 8'd8, 1'b1);
        push(10'd50, 8'd3, 1'b0);
        push(10'd60, 8'd3, 1'b0);
        next_tick();
        check("ab_pos_pre", 32'(pos_o), 12);
        check("ab_busy_pre", 32'(busy_o), 1);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        check("ab_done", 32'(move_done_o), 1);
        check("ab_pos", 32'(pos_o), 12);
        check("ab_vel", 32'(vel_o), 0);
        check("ab_secs", 32'(move_seconds_o), 1);
        check("ab_moves", 32'(moves_done_o), 5);
        cyc();
        check("ab_busy", 32'(busy_o), 0);
        check("ab_ready", 32'(cmd_ready_o), 1);
        for (int i = 0; i < 16; i++) cyc();
        check("ab_pos_hold", 32'(pos_o), 12);
        check("ab_moves_hold", 32'(moves_done_o), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
